// File: rtl/nearest_search_pkg.sv
// Shared types and constants for the nearest_search block.
// NEAREST_SEARCH_TIE_LAST_EN selects the tie rule inside nearest_cmp.
package nearest_pkg;

    localparam int DATA_W = 8;
    localparam int DIST_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A run length is legal when it is in 1..max_len.
    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len != 32'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/nearest_search_cmp.sv
// Combinational nearest-value compare: picks a or b, whichever is closer to ref.
// NEAREST_SEARCH_TIE_LAST_EN defined -> ties select b; otherwise ties keep a.
module nearest_cmp
    import nearest_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_ref,
    output logic              o_sel_b,
    output logic [DATA_W-1:0] o_val
);

    logic signed [DATA_W:0] w_diff_a;
    logic signed [DATA_W:0] w_diff_b;
    logic signed [DATA_W:0] w_neg_a;
    logic signed [DATA_W:0] w_neg_b;
    logic [DIST_W-1:0]      w_dist_a;
    logic [DIST_W-1:0]      w_dist_b;

    // 9-bit signed differences keep 0 and 255 from wrapping; magnitude fits in 8 bits.
    always_comb begin
        w_diff_a = $signed({1'b0, i_a}) - $signed({1'b0, i_ref});
        w_diff_b = $signed({1'b0, i_b}) - $signed({1'b0, i_ref});
        w_neg_a  = -w_diff_a;
        w_neg_b  = -w_diff_b;
        if (w_diff_a[DATA_W]) begin
            w_dist_a = w_neg_a[DIST_W-1:0];
        end else begin
            w_dist_a = w_diff_a[DIST_W-1:0];
        end
        if (w_diff_b[DATA_W]) begin
            w_dist_b = w_neg_b[DIST_W-1:0];
        end else begin
            w_dist_b = w_diff_b[DIST_W-1:0];
        end
    end

    // Tie rule and chosen value.
    always_comb begin
`ifdef NEAREST_SEARCH_TIE_LAST_EN
        o_sel_b = (w_dist_b <= w_dist_a);
`else
        o_sel_b = (w_dist_b < w_dist_a);
`endif
        if (o_sel_b) begin
            o_val = i_b;
        end else begin
            o_val = i_a;
        end
    end

endmodule

// File: rtl/nearest_search.sv
// Handshaked, length-programmable scan tracking the sample nearest a latched reference.
// Tie behaviour is set by NEAREST_SEARCH_TIE_LAST_EN (see nearest_cmp).
module nearest_search
    import nearest_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_ref,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_best,
    output logic [IDX_W-1:0]  o_best_idx,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_ref;
    logic [LEN_W-1:0]  r_len;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_best;
    logic [IDX_W-1:0]  r_best_idx;

    logic              w_len_ok;
    logic              w_accept;
    logic              w_beat;
    logic              w_last;
    logic              w_sel_b;
    logic [DATA_W-1:0] w_cmp_val;

    assign w_len_ok = len_legal(32'(i_len), 32'(MAX_LEN));
    assign w_accept = (r_state == IDLE) && i_start && w_len_ok;
    assign w_beat   = (r_state == RUN) && i_in_valid;
    assign w_last   = ({1'b0, r_cnt} == (r_len - LEN_ONE));

    nearest_cmp u_cmp (
        .i_a     (r_best),
        .i_b     (i_in_data),
        .i_ref   (r_ref),
        .o_sel_b (w_sel_b),
        .o_val   (w_cmp_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; handshake/status outputs decode the state register only.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_beat && w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Run parameters, beat counter and the tracked best sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref      <= {DATA_W{1'b0}};
            r_len      <= {LEN_W{1'b0}};
            r_cnt      <= IDX_ZERO;
            r_best     <= {DATA_W{1'b0}};
            r_best_idx <= IDX_ZERO;
        end else if (w_accept) begin
            r_ref <= i_ref;
            r_len <= i_len;
            r_cnt <= IDX_ZERO;
        end else if (w_beat) begin
            if (r_cnt == IDX_ZERO) begin
                r_best     <= i_in_data;
                r_best_idx <= IDX_ZERO;
            end else if (w_sel_b) begin
                r_best     <= w_cmp_val;
                r_best_idx <= r_cnt;
            end
            // Counter parks on the last beat so a full-length run cannot wrap it.
            if (!w_last) begin
                r_cnt <= r_cnt + IDX_ONE;
            end
        end
    end

    assign o_best     = r_best;
    assign o_best_idx = r_best_idx;

endmodule

// File: tb/tb_nearest_search.sv
// Scoreboard bench for nearest_search: runs directed and random scans against a reference model.
module tb_nearest_search;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int IDX_W   = 4;

    typedef struct {
        logic [7:0]       best;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [7:0]       i_ref;
    logic [LEN_W-1:0] i_len;
    logic             i_in_valid;
    logic [7:0]       i_in_data;
    logic             o_in_ready;
    logic [7:0]       o_best;
    logic [IDX_W-1:0] o_best_idx;
    logic             o_busy;
    logic             o_done;

    int   checks;
    int   errors;
    int   done_cnt;
    int   exp_dones;
    logic prev_done;
    exp_t sb[$];
    exp_t last_exp;
    int   smp[MAX_LEN];

    nearest_search #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_ref      (i_ref),
        .i_len      (i_len),
        .i_in_valid (i_in_valid),
        .i_in_data  (i_in_data),
        .o_in_ready (o_in_ready),
        .o_best     (o_best),
        .o_best_idx (o_best_idx),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Nearest sample by minimum distance over the whole run; ties resolved by position.
    function automatic exp_t model(input int rv, input int n);
        exp_t e;
        int   dmin;
        int   d;
        dmin  = 1000;
        e.best = 8'd0;
        e.idx  = '0;
        for (int k = 0; k < n; k++) begin
            d = (smp[k] > rv) ? smp[k] - rv : rv - smp[k];
            if (d < dmin) dmin = d;
        end
        for (int k = n - 1; k >= 0; k--) begin
            d = (smp[k] > rv) ? smp[k] - rv : rv - smp[k];
`ifdef NEAREST_SEARCH_TIE_LAST_EN
            if (d == dmin && e.best === 8'd0 && e.idx == '0 && k >= 0) begin
                if (k == n - 1 || !(model_hit(rv, n, dmin, k))) begin
                    e.best = smp[k][7:0];
                    e.idx  = k[IDX_W-1:0];
                end
            end
`else
            if (d == dmin) begin
                e.best = smp[k][7:0];
                e.idx  = k[IDX_W-1:0];
            end
`endif
        end
        return e;
    endfunction

    // True if a later sample than k also sits at the minimum distance.
    function automatic bit model_hit(input int rv, input int n, input int dmin, input int k);
        int d;
        for (int j = k + 1; j < n; j++) begin
            d = (smp[j] > rv) ? smp[j] - rv : rv - smp[j];
            if (d == dmin) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            exp_t e;
            done_cnt++;
            chk("done_width", int'(prev_done), 0);
            chk("busy_with_done", int'(o_busy), 1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("best", int'(o_best), int'(e.best));
                chk("best_idx", int'(o_best_idx), int'(e.idx));
            end
        end
        prev_done = o_done;
    end

    task automatic run_scan(input int rv, input int n, input int gap, input bit rnd_gap, input bit poke);
        exp_t e;
        int   g;
        e = model(rv, n);
        sb.push_back(e);
        exp_dones++;
        last_exp   = e;
        i_ref      = rv[7:0];
        i_len      = n[LEN_W-1:0];
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_ref   = 8'($urandom);
        i_len   = LEN_W'($urandom_range(1, MAX_LEN));
        for (int k = 0; k < n; k++) begin
            g = rnd_gap ? $urandom_range(0, 2) : gap;
            for (int j = 0; j < g; j++) begin
                i_in_valid = 1'b0;
                i_in_data  = 8'($urandom);
                if (poke && j == 0) i_start = 1'b1;
                @(posedge clk); #1;
                i_start = 1'b0;
            end
            chk("in_ready_run", int'(o_in_ready), 1);
            i_in_valid = 1'b1;
            i_in_data  = smp[k][7:0];
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0;
        chk("done_after_last", int'(o_done), 1);
        chk("ready_in_done", int'(o_in_ready), 0);
        @(posedge clk); #1;
        chk("done_low", int'(o_done), 0);
        chk("busy_low", int'(o_busy), 0);
        chk("best_hold", int'(o_best), int'(e.best));
        chk("idx_hold", int'(o_best_idx), int'(e.idx));
    endtask

    task automatic bad_start(input int n);
        i_len   = n[LEN_W-1:0];
        i_ref   = 8'($urandom);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("illegal_busy", int'(o_busy), 0);
        chk("illegal_ready", int'(o_in_ready), 0);
        chk("illegal_best", int'(o_best), int'(last_exp.best));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv;
        int n;
        checks = 0; errors = 0; done_cnt = 0; exp_dones = 0; prev_done = 1'b0;
        rst_n = 1'b0; i_start = 1'b0; i_ref = 8'd0; i_len = '0;
        i_in_valid = 1'b0; i_in_data = 8'd0;
        @(posedge clk); #1;
        chk("rst_best", int'(o_best), 0);
        chk("rst_idx", int'(o_best_idx), 0);
        chk("rst_ready", int'(o_in_ready), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        smp[0] = 10; smp[1] = 90; smp[2] = 130; smp[3] = 105;
        run_scan(100, 4, 0, 1'b0, 1'b0);
        smp[0] = 40; smp[1] = 60;
        run_scan(50, 2, 0, 1'b0, 1'b0);
        smp[0] = 255; smp[1] = 1; smp[2] = 0;
        run_scan(0, 3, 0, 1'b0, 1'b0);
        smp[0] = 0; smp[1] = 254;
        run_scan(255, 2, 0, 1'b0, 1'b0);
        smp[0] = 30; smp[1] = 15; smp[2] = 21;
        run_scan(20, 3, 3, 1'b0, 1'b1);

        // Reset in the middle of a run.
        i_ref = 8'd7; i_len = 5'd5; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_in_valid = 1'b1; i_in_data = 8'd3;
        @(posedge clk); #1;
        i_in_data = 8'd11;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_best", int'(o_best), 0);
        chk("midrst_idx", int'(o_best_idx), 0);
        chk("midrst_ready", int'(o_in_ready), 0);
        chk("midrst_busy", int'(o_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_exp.best = 8'd0;
        last_exp.idx  = '0;
        bad_start(0);
        smp[0] = 9;
        run_scan(7, 1, 0, 1'b0, 1'b0);

        bad_start(0);
        bad_start(17);
        repeat (3) @(posedge clk);
        #1 chk("no_spurious_done", done_cnt, exp_dones);
        run_scan(200, MAX_LEN, 0, 1'b1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            rv = $urandom_range(0, 255);
            n  = $urandom_range(1, MAX_LEN);
            for (int k = 0; k < n; k++) begin
                if (r % 2 == 0) begin
                    smp[k] = rv + $urandom_range(0, 6) - 3;
                    if (smp[k] < 0) smp[k] = 0;
                    if (smp[k] > 255) smp[k] = 255;
                end else begin
                    smp[k] = $urandom_range(0, 255);
                end
            end
            run_scan(rv, n, 0, 1'b1, r % 3 == 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("done_count", done_cnt, exp_dones);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
